// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture path.
// Holds the capture FSM encoding and the default sample width.
package scope_pkg;

    localparam int SCOPE_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: write port A, registered read port B.
// Ports: clk_i, rst_i (clears read register only), we_i/waddr_i/wdata_i, raddr_i/rdata_o.
// Read-first: a same-cycle write to the read address returns the old word.
module capture_ram
    import scope_pkg::*;
#(
    parameter int DATA_W = SCOPE_DATA_W,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_buffer.sv
// Trigger-qualified circular sample capture; freezes a frame for the reader.
// Ports: clk_AD, rst (sync, high), sample_in, trigger, arm, frame_ack, rd_addr ->
//   rd_data, start_addr, trig_addr, frame_valid, busy, auto_fired.
// Optional: define AUTO_TRIG_EN to force a capture after AUTO_TIMEOUT armed cycles.
module capture_buffer
    import scope_pkg::*;
#(
    parameter int DATA_W       = SCOPE_DATA_W,
    parameter int ADDR_W       = 10,
    parameter int PRE_DEPTH    = 256,
    parameter int AUTO_TIMEOUT = 1048576
) (
    input  logic              clk_AD,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              trigger,
    input  logic              arm,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              frame_valid,
    output logic              busy,
    output logic              auto_fired
);

    localparam int DEPTH    = 2**ADDR_W;
    localparam int POST_LEN = DEPTH - PRE_DEPTH;

    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_DEPTH - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t            state_q, state_d;
    logic              trig_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] pre_cnt_q;
    logic [ADDR_W-1:0] post_cnt_q;
    logic [ADDR_W-1:0] trig_addr_q;
    logic              trig_seen_q;
    logic              wr_en;
    logic              trig_edge;
    logic              auto_hit;
    logic              fire;

    assign trig_edge = trigger & ~trig_q;

`ifdef AUTO_TRIG_EN
    localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             auto_fired_q;

    // Held at zero outside ARMED, so every ARMED entry starts from zero.
    always_ff @(posedge clk_AD) begin
        if (rst || state_q != S_ARMED) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign auto_hit = (tmo_q == TMO_W'(AUTO_TIMEOUT - 1));

    // A real edge on the timeout cycle wins, so auto_fired stays low then.
    always_ff @(posedge clk_AD) begin
        if (rst) begin
            auto_fired_q <= 1'b0;
        end else if (state_q == S_IDLE && arm) begin
            auto_fired_q <= 1'b0;
        end else if (fire) begin
            auto_fired_q <= ~trig_edge;
        end
    end

    assign auto_fired = auto_fired_q;
`else
    assign auto_hit   = 1'b0;
    assign auto_fired = 1'b0;
`endif

    assign fire = (state_q == S_ARMED) & (trig_edge | auto_hit);

    always_ff @(posedge clk_AD) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (arm) state_d = S_PRETRIG;
            S_PRETRIG: if (pre_cnt_q == PRE_LAST) state_d = S_ARMED;
            // With a one-sample post window the trigger write is the last one.
            S_ARMED:   if (fire) state_d = (POST_LEN == 1) ? S_DONE : S_POST;
            S_POST:    if (post_cnt_q == POST_LAST) state_d = S_DONE;
            S_DONE:    if (frame_ack) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_en       = 1'b0;
        busy        = 1'b0;
        frame_valid = 1'b0;
        unique case (state_q)
            S_PRETRIG, S_ARMED, S_POST: begin
                wr_en = 1'b1;
                busy  = 1'b1;
            end
            S_DONE:  frame_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_AD) begin
        if (rst) begin
            trig_q      <= 1'b0;
            wr_ptr_q    <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            trig_seen_q <= 1'b0;
        end else begin
            trig_q <= trigger;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ONE;
            end
            if (state_q == S_IDLE && arm) begin
                pre_cnt_q <= '0;
            end
            if (state_q == S_PRETRIG) begin
                pre_cnt_q <= pre_cnt_q + ONE;
            end
            if (fire) begin
                trig_addr_q <= wr_ptr_q;
                trig_seen_q <= 1'b1;
                post_cnt_q  <= ONE;
            end
            if (state_q == S_POST) begin
                post_cnt_q <= post_cnt_q + ONE;
            end
        end
    end

    // start_addr reads zero until the first trigger since reset has been recorded.
    assign trig_addr  = trig_addr_q;
    assign start_addr = trig_seen_q ? (trig_addr_q - ADDR_W'(PRE_DEPTH)) : '0;

    capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_AD),
        .rst_i   (rst),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (sample_in),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer (ramp, held trigger, DONE freeze,
// mid-capture reset, optional AUTO_TRIG_EN timeout).
module tb_capture_buffer;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int PRE   = 256;
    localparam int POSTN = DEPTH - PRE;
    localparam int TMO   = 100;

    logic          clk_AD = 1'b0;
    logic          rst;
    logic [DW-1:0] sample_in;
    logic          trigger;
    logic          arm;
    logic          frame_ack;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] trig_addr;
    logic          frame_valid;
    logic          busy;
    logic          auto_fired;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] rdq [$];
    int            wp;
    bit            wexp;
    bit            ramp;
    int            rcnt;
    int            ta;
    bit            seen;

    capture_buffer #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .PRE_DEPTH    (PRE),
        .AUTO_TIMEOUT (TMO)
    ) dut (
        .clk_AD      (clk_AD),
        .rst         (rst),
        .sample_in   (sample_in),
        .trigger     (trigger),
        .arm         (arm),
        .frame_ack   (frame_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .start_addr  (start_addr),
        .trig_addr   (trig_addr),
        .frame_valid (frame_valid),
        .busy        (busy),
        .auto_fired  (auto_fired)
    );

    always #5 clk_AD = ~clk_AD;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, log the expected write, sample #1 after the edge.
    task automatic step(input logic a, input logic t, input logic ack);
        logic [DW-1:0] s;
        s = ramp ? DW'(rcnt) : DW'($urandom);
        rcnt++;
        arm       = a;
        trigger   = t;
        frame_ack = ack;
        sample_in = s;
        if (wexp) begin
            exp_mem[wp % DEPTH] = s;
            wp++;
        end
        @(posedge clk_AD);
        #1;
    endtask

    task automatic rd(input int a);
        rd_addr = AW'(a);
        rdq.push_back(exp_mem[a % DEPTH]);
        step(1'b0, trigger, 1'b0);
        chk("rd_data", rd_data, rdq.pop_front());
    endtask

    // Called right after the edge-capturing step, which counts as tick 1.
    task automatic wait_fv(input string tag);
        int n;
        n = 1;
        while (!frame_valid && n < POSTN + 10) begin
            step(1'b0, trigger, 1'b0);
            n++;
        end
        wexp = 1'b0;
        chk(tag, n, POSTN);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; trigger = 1'b0; frame_ack = 1'b0;
        sample_in = '0; rd_addr = '0;
        wexp = 1'b0; ramp = 1'b1; rcnt = 0; wp = 0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_start", start_addr, 0);
        chk("rst_trig", trig_addr, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_auto", auto_fired, 0);

        // Ramp frame, trigger on sample 300; a pulse during PRETRIG is ignored.
        step(1'b1, 1'b0, 1'b0);
        chk("arm_busy", busy, 1);
        rcnt = 0; wexp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, (i == 200), 1'b0);
        end
        chk("armed_busy", busy, 1);
        chk("armed_fv", frame_valid, 0);
        step(1'b0, 1'b1, 1'b0);
        wait_fv("ramp_fv_lat");
        chk("ramp_trig", trig_addr, 300);
        chk("ramp_start", start_addr, 44);
        chk("done_busy", busy, 0);
        rd(44);
        chk("rd44_val", rd_data, 44);
        for (int a = 0; a < DEPTH; a += 97) rd(a);

        // DONE freeze: samples keep moving, RAM must not.
        ramp = 1'b0;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
        for (int a = 3; a < DEPTH; a += 101) rd(a);
        chk("freeze_fv", frame_valid, 1);
        step(1'b0, 1'b0, 1'b1);
        chk("ack_fv", frame_valid, 0);
        chk("ack_busy", busy, 0);

        // Trigger already high at arm and held: only a fresh rise fires.
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        wexp = 1'b1;
        for (int i = 0; i < 400; i++) step(1'b0, 1'b1, (i == 10));
        chk("held_fv", frame_valid, 0);
        chk("held_busy", busy, 1);
        step(1'b0, 1'b0, 1'b0);
        ta = wp % DEPTH;
        step(1'b0, 1'b1, 1'b0);
        wait_fv("held_fv_lat");
        chk("held_trig", trig_addr, ta);
        chk("held_start", start_addr, (ta - PRE) & (DEPTH - 1));
        rd(ta);
        rd((ta - PRE) & (DEPTH - 1));
        rd((ta + 500) % DEPTH);
        step(1'b0, 1'b0, 1'b1);

        // Reset in POST, together with arm: back to IDLE, nothing frozen.
        step(1'b1, 1'b0, 1'b0);
        wexp = 1'b1;
        for (int i = 0; i < 266; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0);
        wexp = 1'b0;
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_trig", trig_addr, 0);
        seen = 1'b0;
        for (int i = 0; i < 800; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (frame_valid || busy) seen = 1'b1;
        end
        chk("mrst_quiet", seen, 0);
        step(1'b1, 1'b0, 1'b0);
        wexp = 1'b1; wp = 0;
        for (int i = 0; i < 261; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        wait_fv("rearm_fv_lat");
        chk("rearm_trig", trig_addr, 261);
        chk("rearm_start", start_addr, 5);
        rd(5);
        rd(261);
        rd(1000);
        step(1'b0, 1'b0, 1'b1);

`ifdef AUTO_TRIG_EN
        step(1'b1, 1'b0, 1'b0);
        wexp = 1'b1;
        for (int i = 0; i < PRE + TMO - 1; i++) step(1'b0, 1'b0, 1'b0);
        chk("auto_pre_fv", busy, 1);
        ta = wp % DEPTH;
        step(1'b0, 1'b0, 1'b0);
        wait_fv("auto_fv_lat");
        chk("auto_flag", auto_fired, 1);
        chk("auto_trig", trig_addr, ta);
        step(1'b0, 1'b0, 1'b1);
        chk("auto_hold", auto_fired, 1);
        step(1'b1, 1'b0, 1'b0);
        chk("auto_clr", auto_fired, 0);
        wexp = 1'b1;
        for (int i = 0; i < PRE + TMO - 1; i++) step(1'b0, 1'b0, 1'b0);
        ta = wp % DEPTH;
        step(1'b0, 1'b1, 1'b0);
        wait_fv("edge100_fv_lat");
        chk("edge100_flag", auto_fired, 0);
        chk("edge100_trig", trig_addr, ta);
        step(1'b0, 1'b0, 1'b1);
`else
        step(1'b1, 1'b0, 1'b0);
        wexp = 1'b1;
        for (int i = 0; i < PRE + 300; i++) step(1'b0, 1'b0, 1'b0);
        chk("noauto_fv", frame_valid, 0);
        chk("noauto_busy", busy, 1);
        chk("noauto_flag", auto_fired, 0);
        ta = wp % DEPTH;
        step(1'b0, 1'b1, 1'b0);
        wait_fv("noauto_fv_lat");
        chk("noauto_trig", trig_addr, ta);
        step(1'b0, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
